// File: rtl/dcache_nway.sv
// N-way set-associative write-back/write-allocate data cache with true-LRU and halt flush.
// Optional hit/miss counter dumped to 0x3100 after flush: define DCACHE_HITCNT_EN.
module dcache_nway #(
  parameter int unsigned WAYS  = 2,
  parameter int unsigned SETS  = 8,
  parameter int unsigned WORDS = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        halt,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic        dwait,
  input  logic [31:0] dload
);

  localparam int unsigned WOFF = (WORDS > 1) ? $clog2(WORDS) : 0;
  localparam int unsigned IDX  = $clog2(SETS);
  localparam int unsigned TAG  = 32 - 2 - WOFF - IDX;
  localparam int unsigned WW   = (WORDS > 1) ? WOFF : 1;
  localparam int unsigned AW   = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB,
    S_FILL,
    S_FLUSH,
`ifdef DCACHE_HITCNT_EN
    S_CNT,
`endif
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [TAG-1:0]  tag_q  [WAYS][SETS];
  logic [TAG-1:0]  tag_d  [WAYS][SETS];
  logic [31:0]     data_q [WAYS][SETS][WORDS];
  logic [31:0]     data_d [WAYS][SETS][WORDS];
  logic [SETS-1:0] valid_q [WAYS];
  logic [SETS-1:0] valid_d [WAYS];
  logic [SETS-1:0] dirty_q [WAYS];
  logic [SETS-1:0] dirty_d [WAYS];
  logic [WAYS-1:0][AW-1:0] age_q [SETS];
  logic [WAYS-1:0][AW-1:0] age_d [SETS];

  logic [AW-1:0]  vway_q, vway_d;
  logic [TAG-1:0] vtag_q, vtag_d;
  logic [TAG-1:0] rtag_q, rtag_d;
  logic [IDX-1:0] idx_q, idx_d;
  logic [WW-1:0]  wcnt_q, wcnt_d;
  logic           halt_seen_q, halt_seen_d;
  logic [IDX-1:0] fset_q, fset_d;
  logic [AW-1:0]  fway_q, fway_d;
`ifdef DCACHE_HITCNT_EN
  logic [31:0]    cnt_q, cnt_d;
`endif

  logic [TAG-1:0] req_tag;
  logic [IDX-1:0] req_idx;
  logic [WW-1:0]  req_word;
  logic           req;
  logic           hit;
  logic [AW-1:0]  hit_way;
  logic           inv_found;
  logic [AW-1:0]  victim;
  logic           last_word;
  logic           f_dirty;
  logic           f_last;
  logic           f_adv;
  logic           addr_unused;

  assign req_tag     = dmemaddr[31 -: TAG];
  assign req_idx     = dmemaddr[2+WOFF +: IDX];
  assign req_word    = (WORDS > 1) ? dmemaddr[2 +: WW] : '0;
  assign req         = dmemREN | dmemWEN;
  assign addr_unused = ^dmemaddr[1:0];
  assign last_word   = (wcnt_q == WW'(WORDS - 1));
  assign f_dirty     = valid_q[fway_q][fset_q] & dirty_q[fway_q][fset_q];
  assign f_last      = (fway_q == AW'(WAYS - 1)) && (fset_q == IDX'(SETS - 1));

  function automatic logic [31:0] mk_addr(input logic [TAG-1:0] t, input logic [IDX-1:0] i,
                                          input logic [WW-1:0] w);
    logic [31:0] a;
    a = (32'(t) << (32 - TAG)) | (32'(i) << (2 + WOFF));
    if (WORDS > 1) a = a | (32'(w) << 2);
    return a;
  endfunction

  // Touched way becomes youngest; only ways younger than it age by one.
  function automatic logic [WAYS-1:0][AW-1:0] lru_touch(input logic [WAYS-1:0][AW-1:0] row,
                                                        input logic [AW-1:0] way);
    logic [WAYS-1:0][AW-1:0] res;
    for (int i = 0; i < WAYS; i++) begin
      if (AW'(i) == way)          res[i] = '0;
      else if (row[i] < row[way]) res[i] = row[i] + AW'(1);
      else                        res[i] = row[i];
    end
    return res;
  endfunction

  // Tag compare across ways of the addressed set.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag)) begin
        hit     = 1'b1;
        hit_way = AW'(w);
      end
    end
  end

  // Victim: lowest invalid way, else the oldest one.
  always_comb begin
    inv_found = 1'b0;
    victim    = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!inv_found && !valid_q[w][req_idx]) begin
        inv_found = 1'b1;
        victim    = AW'(w);
      end
    end
    if (!inv_found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_q[req_idx][w] == AW'(WAYS - 1)) victim = AW'(w);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    tag_d       = tag_q;
    data_d      = data_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    age_d       = age_q;
    vway_d      = vway_q;
    vtag_d      = vtag_q;
    rtag_d      = rtag_q;
    idx_d       = idx_q;
    wcnt_d      = wcnt_q;
    halt_seen_d = halt_seen_q;
    fset_d      = fset_q;
    fway_d      = fway_q;
`ifdef DCACHE_HITCNT_EN
    cnt_d       = cnt_q;
`endif
    f_adv       = 1'b0;
    dhit        = 1'b0;
    dmemload    = '0;
    flushed     = 1'b0;
    dREN        = 1'b0;
    dWEN        = 1'b0;
    daddr       = '0;
    dstore      = '0;

    case (state_q)
      S_IDLE: begin
        if (halt) begin
          state_d = S_FLUSH;
        end else if (req) begin
          if (hit) begin
            dhit           = 1'b1;
            age_d[req_idx] = lru_touch(age_q[req_idx], hit_way);
`ifdef DCACHE_HITCNT_EN
            cnt_d          = cnt_q + 32'd1;
`endif
            if (dmemWEN) begin
              data_d[hit_way][req_idx][req_word] = dmemstore;
              dirty_d[hit_way][req_idx]          = 1'b1;
            end else begin
              dmemload = data_q[hit_way][req_idx][req_word];
            end
          end else begin
            vway_d  = victim;
            vtag_d  = tag_q[victim][req_idx];
            rtag_d  = req_tag;
            idx_d   = req_idx;
            wcnt_d  = '0;
            state_d = (valid_q[victim][req_idx] && dirty_q[victim][req_idx]) ? S_WB : S_FILL;
`ifdef DCACHE_HITCNT_EN
            cnt_d   = cnt_q - 32'd1;
`endif
          end
        end
      end

      S_WB: begin
        if (halt) halt_seen_d = 1'b1;
        dWEN   = 1'b1;
        daddr  = mk_addr(vtag_q, idx_q, wcnt_q);
        dstore = data_q[vway_q][idx_q][wcnt_q];
        if (!dwait) begin
          if (last_word) begin
            wcnt_d  = '0;
            state_d = S_FILL;
          end else begin
            wcnt_d = wcnt_q + WW'(1);
          end
        end
      end

      S_FILL: begin
        if (halt) halt_seen_d = 1'b1;
        dREN  = 1'b1;
        daddr = mk_addr(rtag_q, idx_q, wcnt_q);
        if (!dwait) begin
          data_d[vway_q][idx_q][wcnt_q] = dload;
          if (last_word) begin
            valid_d[vway_q][idx_q] = 1'b1;
            dirty_d[vway_q][idx_q] = 1'b0;
            tag_d[vway_q][idx_q]   = rtag_q;
            age_d[idx_q]           = lru_touch(age_q[idx_q], vway_q);
            wcnt_d                 = '0;
            state_d                = (halt || halt_seen_q) ? S_FLUSH : S_IDLE;
          end else begin
            wcnt_d = wcnt_q + WW'(1);
          end
        end
      end

      // Set-major scan; dirty lines are written back word by word.
      S_FLUSH: begin
        if (f_dirty) begin
          dWEN   = 1'b1;
          daddr  = mk_addr(tag_q[fway_q][fset_q], fset_q, wcnt_q);
          dstore = data_q[fway_q][fset_q][wcnt_q];
          if (!dwait) begin
            if (last_word) begin
              dirty_d[fway_q][fset_q] = 1'b0;
              wcnt_d                  = '0;
              f_adv                   = 1'b1;
            end else begin
              wcnt_d = wcnt_q + WW'(1);
            end
          end
        end else begin
          f_adv = 1'b1;
        end
        if (f_adv) begin
          if (f_last) begin
`ifdef DCACHE_HITCNT_EN
            state_d = S_CNT;
`else
            state_d = S_DONE;
`endif
          end else if (fway_q == AW'(WAYS - 1)) begin
            fway_d = '0;
            fset_d = fset_q + IDX'(1);
          end else begin
            fway_d = fway_q + AW'(1);
          end
        end
      end

`ifdef DCACHE_HITCNT_EN
      S_CNT: begin
        dWEN   = 1'b1;
        daddr  = 32'h0000_3100;
        dstore = cnt_q;
        if (!dwait) state_d = S_DONE;
      end
`endif

      S_DONE: begin
        flushed = 1'b1;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      for (int w = 0; w < WAYS; w++) begin
        valid_q[w] <= '0;
        dirty_q[w] <= '0;
        for (int s = 0; s < SETS; s++) begin
          tag_q[w][s] <= '0;
          for (int k = 0; k < WORDS; k++) data_q[w][s][k] <= '0;
        end
      end
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= AW'(w);
      end
      vway_q      <= '0;
      vtag_q      <= '0;
      rtag_q      <= '0;
      idx_q       <= '0;
      wcnt_q      <= '0;
      halt_seen_q <= 1'b0;
      fset_q      <= '0;
      fway_q      <= '0;
`ifdef DCACHE_HITCNT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      age_q       <= age_d;
      vway_q      <= vway_d;
      vtag_q      <= vtag_d;
      rtag_q      <= rtag_d;
      idx_q       <= idx_d;
      wcnt_q      <= wcnt_d;
      halt_seen_q <= halt_seen_d;
      fset_q      <= fset_d;
      fway_q      <= fway_d;
`ifdef DCACHE_HITCNT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_dcache_nway.sv
// Scoreboard bench for dcache_nway (WAYS=2, SETS=8, WORDS=2) with a latency-programmable memory.
module tb_dcache_nway;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        halt = 1'b0;
  logic        dmemREN = 1'b0;
  logic        dmemWEN = 1'b0;
  logic [31:0] dmemaddr = '0;
  logic [31:0] dmemstore = '0;
  logic        dhit;
  logic [31:0] dmemload;
  logic        flushed;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait = 1'b0;
  logic [31:0] dload = '0;

  dcache_nway #(.WAYS(2), .SETS(8), .WORDS(2)) dut (
    .CLK(CLK), .nRST(nRST), .halt(halt),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t        exp_txn[$];
  logic [31:0] exp_load[$];
  logic [31:0] mem [logic [31:0]];

  int          n_checks = 0;
  int          n_pass = 0;
  int          lat = 0;
  int          lat_cnt = 0;
  bit          holding = 1'b0;
  logic [31:0] hold_addr = '0;
  int          done_cnt = 0;
  logic [31:0] exp_cnt = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 32'h5EED_0000);
  endfunction

  task automatic push_txn(input logic wr, input logic [31:0] a, input logic [31:0] d);
    txn_t t;
    t.wr = wr; t.addr = a; t.data = d;
    exp_txn.push_back(t);
  endtask

  // Memory slave: answers after 'lat' wait cycles and checks every completed transfer.
  always @(negedge CLK) begin
    if (!(nRST && (dREN || dWEN))) begin
      lat_cnt = 0;
      holding = 1'b0;
      dwait   = 1'b0;
    end else begin
      check("rw_exclusive", 32'(dREN & dWEN), 32'd0);
      if (holding) check("addr_stable", daddr, hold_addr);
      if (lat_cnt == lat) begin
        dwait = 1'b0;
        dload = mem_rd(daddr);
        if (dWEN) mem[daddr] = dstore;
        if (exp_txn.size() == 0) begin
          check("txn_extra", daddr, 32'hFFFF_FFFF);
        end else begin
          txn_t e;
          e = exp_txn.pop_front();
          check("txn_kind", 32'(dWEN), 32'(e.wr));
          check("txn_addr", daddr, e.addr);
          if (e.wr) check("txn_data", dstore, e.data);
        end
        lat_cnt = 0;
        holding = 1'b0;
        done_cnt++;
      end else begin
        dwait     = 1'b1;
        lat_cnt++;
        holding   = 1'b1;
        hold_addr = daddr;
      end
    end
  end

  task automatic check_quiet(input string tag);
    check({tag, "_dhit"},     32'(dhit),    32'd0);
    check({tag, "_dmemload"}, dmemload,     32'd0);
    check({tag, "_flushed"},  32'(flushed), 32'd0);
    check({tag, "_dREN"},     32'(dREN),    32'd0);
    check({tag, "_dWEN"},     32'(dWEN),    32'd0);
    check({tag, "_daddr"},    daddr,        32'd0);
    check({tag, "_dstore"},   dstore,       32'd0);
  endtask

  // One datapath request; expected load is queued at drive time and popped on dhit.
  task automatic req(input logic wr, input logic [31:0] a, input logic [31:0] d,
                     input int exp_lat);
    int cyc;
    bit got;
    @(negedge CLK);
    dmemaddr  = a;
    dmemstore = d;
    dmemREN   = !wr;
    dmemWEN   = wr;
    if (!wr) exp_load.push_back(d);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 200) begin
      #1;
      if (dhit) got = 1'b1;
      else begin
        cyc++;
        @(negedge CLK);
      end
    end
    check("hit_seen", 32'(got), 32'd1);
    if (got) begin
      check("latency", 32'(cyc), 32'(exp_lat));
      if (!wr) check("load_data", dmemload, exp_load.pop_front());
    end
    @(posedge CLK);
    #1;
    dmemREN = 1'b0;
    dmemWEN = 1'b0;
    exp_cnt = exp_cnt + 32'd1;
    if (exp_lat > 0) exp_cnt = exp_cnt - 32'd1;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    int base;
    bit ok;
    mem[32'h40] = 32'hDEAD_BEEF;
    mem[32'h44] = 32'h1234_5678;

    repeat (2) @(negedge CLK);
    #1 check_quiet("in_reset");
    @(negedge CLK) nRST = 1'b1;
    #1 check_quiet("after_reset");

    // Cold fill then same-line hit.
    push_txn(1'b0, 32'h40, 0); push_txn(1'b0, 32'h44, 0);
    req(1'b0, 32'h40, 32'hDEAD_BEEF, 3);
    req(1'b0, 32'h44, 32'h1234_5678, 0);

    // Dirty eviction of the LRU way.
    req(1'b1, 32'h40, 32'hAAAA_5555, 0);
    push_txn(1'b0, 32'hC0, 0); push_txn(1'b0, 32'hC4, 0);
    req(1'b0, 32'hC0, mem_rd(32'hC0), 3);
    push_txn(1'b1, 32'h40, 32'hAAAA_5555); push_txn(1'b1, 32'h44, 32'h1234_5678);
    push_txn(1'b0, 32'h140, 0); push_txn(1'b0, 32'h144, 0);
    req(1'b0, 32'h140, mem_rd(32'h140), 5);

    // LRU ordering in set 1, all clean.
    push_txn(1'b0, 32'h48, 0); push_txn(1'b0, 32'h4C, 0);
    req(1'b0, 32'h48, mem_rd(32'h48), 3);
    push_txn(1'b0, 32'hC8, 0); push_txn(1'b0, 32'hCC, 0);
    req(1'b0, 32'hC8, mem_rd(32'hC8), 3);
    req(1'b0, 32'h48, mem_rd(32'h48), 0);
    push_txn(1'b0, 32'h148, 0); push_txn(1'b0, 32'h14C, 0);
    req(1'b0, 32'h148, mem_rd(32'h148), 3);
    req(1'b0, 32'h48, mem_rd(32'h48), 0);
    push_txn(1'b0, 32'hC8, 0); push_txn(1'b0, 32'hCC, 0);
    req(1'b0, 32'hC8, mem_rd(32'hC8), 3);

    // Slow memory: 5 wait cycles per word.
    lat = 5;
    push_txn(1'b0, 32'h210, 0); push_txn(1'b0, 32'h214, 0);
    req(1'b0, 32'h210, mem_rd(32'h210), 13);
    lat = 0;

    // Dirty set0/way1 and set3/way0, then flush.
    req(1'b1, 32'hC0, 32'h0C0C_0C0C, 0);
    push_txn(1'b0, 32'h58, 0); push_txn(1'b0, 32'h5C, 0);
    req(1'b1, 32'h58, 32'h5858_5858, 3);
    push_txn(1'b1, 32'hC0, 32'h0C0C_0C0C); push_txn(1'b1, 32'hC4, mem_rd(32'hC4));
    push_txn(1'b1, 32'h58, 32'h5858_5858); push_txn(1'b1, 32'h5C, mem_rd(32'h5C));
`ifdef DCACHE_HITCNT_EN
    push_txn(1'b1, 32'h3100, exp_cnt);
`endif
    @(negedge CLK) halt = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge CLK);
      #1;
      if (flushed) ok = 1'b1;
    end
    check("flushed", 32'(flushed), 32'd1);
    check("flush_txns_left", 32'(exp_txn.size()), 32'd0);
    dmemREN  = 1'b1;
    dmemaddr = 32'h140;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      #1;
      check("done_no_hit", 32'(dhit), 32'd0);
      check("done_no_mem", 32'(dREN | dWEN), 32'd0);
      check("flushed_sticky", 32'(flushed), 32'd1);
    end
    dmemREN = 1'b0;
    halt    = 1'b0;
    @(negedge CLK) nRST = 1'b0;
    #1 check("flushed_cleared", 32'(flushed), 32'd0);
    @(negedge CLK) nRST = 1'b1;

    // Reset while the second fill word is outstanding.
    lat = 2;
    push_txn(1'b0, 32'h40, 0); push_txn(1'b0, 32'h44, 0);
    base = done_cnt;
    @(negedge CLK);
    dmemaddr = 32'h40;
    dmemREN  = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge CLK);
      if (done_cnt == base + 1) ok = 1'b1;
    end
    check("fill_word0_done", 32'(ok), 32'd1);
    @(negedge CLK);
    #1 check("in_fill_word1", 32'(dREN), 32'd1);
    check("fill_word1_addr", daddr, 32'h44);
    nRST = 1'b1;
    nRST = 1'b0;
    #1 check_quiet("mid_fill_reset");
    exp_txn.delete();
    exp_load.delete();
    dmemREN = 1'b0;
    @(negedge CLK) nRST = 1'b1;
    lat = 0;
    push_txn(1'b0, 32'h40, 0); push_txn(1'b0, 32'h44, 0);
    req(1'b0, 32'h40, 32'hAAAA_5555, 3);

    repeat (2) @(negedge CLK);
    check("txn_queue_empty", 32'(exp_txn.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
